// File: rtl/bus_controller.sv
// bus_controller: round-robin arbiter that sequences register-to-register
// transfers over a shared bus (DRIVE -> LATCH -> DONE).
// Optional macro BUS_CTRL_FAST_EN: skip the DRIVE settle cycle (IDLE -> LATCH).
module bus_controller #(
   parameter int NREQ = 4,
   parameter int NREG = 4,
   parameter int SELW = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*SELW-1:0] req_src,
   input  logic [NREQ*SELW-1:0] req_dst,
   output logic [NREQ-1:0]      grant,
   output logic [NREQ-1:0]      done,
   output logic [NREG-1:0]      reg_oe,
   output logic [NREG-1:0]      reg_ie,
   output logic                 busy
);

   localparam int WW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, DRIVE, LATCH, DONE} state_t;

   state_t          state_reg, state_next;
   logic [WW-1:0]   ptr_reg, ptr_next;
   logic [WW-1:0]   owner_reg, owner_next;
   logic [SELW-1:0] src_reg, src_next;
   logic [SELW-1:0] dst_reg, dst_next;
   logic [WW-1:0]   pick;
   logic            found;
   int              rr_j;
   logic            oe_on, ie_on;

   // Round-robin search: first requester at or after ptr (wrapping).
   always_comb begin
      found = 1'b0;
      pick  = '0;
      rr_j  = 0;
      for (int k = 0; k < NREQ; k++) begin
         rr_j = int'(ptr_reg) + k;
         if (rr_j >= NREQ) rr_j = rr_j - NREQ;
         if (!found && req[rr_j]) begin
            found = 1'b1;
            pick  = WW'(rr_j);
         end
      end
   end

   // Next-state logic; src/dst/owner are captured only when leaving IDLE.
   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      owner_next = owner_reg;
      src_next   = src_reg;
      dst_next   = dst_reg;
      case (state_reg)
         IDLE: begin
            if (found) begin
               owner_next = pick;
               src_next   = req_src[int'(pick)*SELW +: SELW];
               dst_next   = req_dst[int'(pick)*SELW +: SELW];
`ifdef BUS_CTRL_FAST_EN
               state_next = LATCH;
`else
               state_next = DRIVE;
`endif
            end
         end
         DRIVE: state_next = LATCH;
         LATCH: state_next = DONE;
         DONE: begin
            state_next = IDLE;
            ptr_next   = (owner_reg == WW'(NREQ - 1)) ? '0 : owner_reg + 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register; reset aborts any transfer in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         owner_reg <= '0;
         src_reg   <= '0;
         dst_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         owner_reg <= owner_next;
         src_reg   <= src_next;
         dst_reg   <= dst_next;
      end
   end

   // A src==dst transfer is a no-op on the bus, so both enables stay low.
   assign oe_on = ((state_reg == DRIVE) || (state_reg == LATCH)) && (src_reg != dst_reg);
   assign ie_on = (state_reg == LATCH) && (src_reg != dst_reg);
   assign busy  = (state_reg != IDLE);

   // Per-requester grant/done decode.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign grant[gi] = (state_reg != IDLE) && (owner_reg == WW'(gi));
      assign done[gi]  = (state_reg == DONE) && (owner_reg == WW'(gi));
   end

   // Per-slice enable decode; an index >= NREG matches no slice.
   for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      assign reg_oe[gi] = oe_on && (src_reg == SELW'(gi));
      assign reg_ie[gi] = ie_on && (dst_reg == SELW'(gi));
   end

endmodule

// File: doc/bus_controller.md
BUS_CONTROLLER -- requirements
Module: bus_controller

Interface
REQ-001 Parameter NREQ, default 4: number of requesters.
REQ-002 Parameter NREG, default 4: number of bit_register slices sharing the bus.
REQ-003 Parameter SELW, default 2: register-select width, with 2^SELW >= NREG.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  NREQ  per-requester transfer request, level, held until done.
REQ-007 req_src  in  NREQ*SELW  packed source register index; requester i uses bits [i*SELW +: SELW].
REQ-008 req_dst  in  NREQ*SELW  packed destination register index, same packing as req_src.
REQ-009 grant  out  NREQ  one-hot owner of the current transfer.
REQ-010 done  out  NREQ  one-cycle completion pulse to the owner.
REQ-011 reg_oe  out  NREG  output_enable to each register slice.
REQ-012 reg_ie  out  NREG  input_enable to each register slice.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 The FSM shall have four states: IDLE, DRIVE, LATCH, DONE.
REQ-015 IDLE: if any req bit is high, pick a winner by round-robin, capture its src/dst, and go to DRIVE; otherwise stay in IDLE.
REQ-016 Round-robin: search starts at pointer ptr; after each DONE, ptr becomes (winner+1) mod NREQ.
REQ-017 DRIVE (bus settle, 1 cycle): grant[w]=1, reg_oe[src]=1, reg_ie all 0; next state LATCH.
REQ-018 LATCH (1 cycle): grant[w]=1, reg_oe[src]=1, reg_ie[dst]=1, so dst captures on the closing edge; next state DONE.
REQ-019 DONE (1 cycle): done[w]=1, grant[w]=1, reg_oe=0, reg_ie=0; next state IDLE.
REQ-020 Latency: req sampled at edge N gives DRIVE in cycle N+1, LATCH in N+2 and DONE in N+3; the earliest next grant is in cycle N+5.
REQ-021 reg_oe shall never have more than one bit set; no register shall ever be driven by two requesters.
REQ-022 src==dst shall be a no-op: DRIVE and LATCH still run, but reg_oe and reg_ie stay all 0; done still pulses.
REQ-023 Captured src/dst shall be held for the whole transfer; req_src, req_dst and req changes after capture shall be ignored.
REQ-024 Dropping req mid-transfer shall not abort it; the transfer completes and done pulses.
REQ-025 A req still high in the IDLE cycle after DONE shall be treated as a new request.
REQ-026 Index >= NREG on src or dst shall suppress the corresponding enable; the transfer still completes with done.
REQ-027 Simultaneous requests shall be served one at a time in round-robin order; no requester waits more than NREQ-1 transfers.

Reset
REQ-028 Reset shall force state=IDLE and ptr=0, and grant, done, reg_oe, reg_ie and busy all to 0 on the next edge.
REQ-029 Reset asserted mid-transfer shall abort it: no done pulse, the destination is unchanged, and enables drop at that edge.
REQ-030 Reset shall take priority over every FSM transition.

Configuration
REQ-031 With macro BUS_CTRL_FAST_EN defined, DRIVE shall be omitted: IDLE goes directly to LATCH, so the transfer takes 3 cycles (LATCH, DONE, IDLE).
REQ-032 Without BUS_CTRL_FAST_EN, the 4-state sequence of REQ-014 to REQ-020 applies unchanged.

Verification
REQ-033 Reset, then req=0001, src0=2, dst0=1 -> cycle+1 reg_oe=0100 ie=0000; +2 oe=0100 ie=0010; +3 done=0001, oe=ie=0.
REQ-034 req=1111 held, each dropped after its done -> grants in order 0001, 0010, 0100, 1000, with ptr wrapping to 0.
REQ-035 req=0010 with src1=dst1=3 -> reg_oe and reg_ie stay 0000 throughout; done=0010 in cycle+3.
REQ-036 reset pulsed in the LATCH cycle -> next cycle all outputs 0, no done, busy=0.
REQ-037 req0 dropped in DRIVE, req2 raised in LATCH -> done=0001 completes, then req2 is granted in the following IDLE.
REQ-038 Build with BUS_CTRL_FAST_EN, req=0001 -> cycle+1 shows LATCH enables, cycle+2 done=0001.
